// File: rtl/noisy_button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// a small elaboration-time helper used to size counters.
package noisy_button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/noisy_button_debouncer_sync_ff.sv
// N-flop synchroniser with asynchronous active-low reset. Generic enough to
// be reused for any single-bit input that is asynchronous to clk.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_d;
  logic [STAGES-1:0] chain_q;

  // Shift the raw input one stage deeper each clock.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // Synchroniser flops; cleared to 0 (button released) on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/noisy_button_debouncer.sv
// Push-button conditioner: synchronises the raw line, qualifies each level
// change over DEBOUNCE_CYCLES identical samples, and emits a one-cycle step
// pulse per accepted press (plus optional auto-repeat pulses while held).
// All outputs are registered off the current FSM state, so they trail the
// qualifying decision by one clock.
module noisy_button_debouncer
  import noisy_button_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  output logic clean,
  output logic pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [RPT_W-1:0] RPT_DLY  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER  = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

  logic s;

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic             rep_phase_q, rep_phase_d;
  logic             first_q, first_d;
  logic             clean_q, clean_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             rpt_fire;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (noisy),
    .q     (s)
  );

  // Counters saturate at all-ones rather than wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign rpt_inc = (rpt_q == '1) ? rpt_q : rpt_q + RPT_ONE;

  // Repeat schedule: first repeat REPEAT_DELAY HELD cycles after the press
  // pulse, then every REPEAT_PERIOD; rpt restarts at 1 after each repeat.
  always_comb begin
    rpt_fire = 1'b0;
    if (REPEAT_EN != 0) begin
      rpt_fire = rep_phase_q ? (rpt_q == RPT_PER) : (rpt_q == RPT_DLY);
    end
  end

  // Next-state, counter and registered-output logic for the debounce FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rpt_d       = rpt_q;
    rep_phase_d = rep_phase_q;
    first_d     = 1'b0;
    clean_d     = 1'b0;
    pulse_d     = 1'b0;
    busy_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        rpt_d       = '0;
        rep_phase_d = 1'b0;
        cnt_d       = '0;
        if (s) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        busy_d = 1'b1;
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          first_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        clean_d = 1'b1;
        if (first_q) begin
          pulse_d = 1'b1;
          rpt_d   = rpt_inc;
        end else if (rpt_fire) begin
          pulse_d     = 1'b1;
          rpt_d       = RPT_ONE;
          rep_phase_d = 1'b1;
        end else begin
          rpt_d = rpt_inc;
        end
        if (!s) begin
          state_d = RELEASE_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_CHK: begin
        busy_d  = 1'b1;
        clean_d = 1'b1;
        if (s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and output registers; reset abandons any qualification.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rpt_q       <= '0;
      rep_phase_q <= 1'b0;
      first_q     <= 1'b0;
      clean_q     <= 1'b0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rpt_q       <= rpt_d;
      rep_phase_q <= rep_phase_d;
      first_q     <= first_d;
      clean_q     <= clean_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
    end
  end

  assign clean = clean_q;
  assign pulse = pulse_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_noisy_button_debouncer.sv
// Bench for the push-button debouncer: two instances (auto-repeat off/on)
// share one button line and are compared every cycle against a level/run
// reference model, plus directed timing checks for the key scenarios.
module tb_noisy_button_debouncer;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int RDLY = 20;
  localparam int RPER = 6;

  logic clk = 1'b0;
  logic reset;
  logic noisy;
  logic clean0, pulse0, busy0;
  logic clean1, pulse1, busy1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: accepted level, length of the current run of samples
  // disagreeing with it, and HELD cycles elapsed since the press.
  bit hist[$];
  bit m_lvl;
  int m_run;
  int m_held;
  bit ep0, ep1, ec, eb;

  always #5 clk = ~clk;

  noisy_button_debouncer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut0 (
    .clk(clk), .reset(reset), .noisy(noisy),
    .clean(clean0), .pulse(pulse0), .busy(busy0)
  );

  noisy_button_debouncer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut1 (
    .clk(clk), .reset(reset), .noisy(noisy),
    .clean(clean1), .pulse(pulse1), .busy(busy1)
  );

  task automatic model_clear();
    hist.delete();
    m_lvl = 1'b0; m_run = 0; m_held = 0;
    ep0 = 1'b0; ep1 = 1'b0; ec = 1'b0; eb = 1'b0;
  endtask

  // Drive one button sample, advance one clock, update the model, settle.
  task automatic step(input bit n);
    bit s;
    bit in_held;
    noisy = n;
    @(posedge clk);
    cyc++;
    s = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
    in_held = m_lvl && (m_run == 0);
    ec  = m_lvl;
    eb  = (m_run != 0);
    ep0 = in_held && (m_held == 0);
    ep1 = in_held && ((m_held == 0) ||
          ((m_held >= RDLY) && (((m_held - RDLY) % RPER) == 0)));
    if (in_held) m_held++;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin
        m_lvl  = !m_lvl;
        m_run  = 0;
        m_held = 0;
      end
    end else begin
      m_run = 0;
    end
    hist.push_back(n);
    while (hist.size() > SYNC) hist.pop_front();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    noisy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec += 2;
    if ({pulse0, clean0, busy0} !== 3'b000) begin
      n_err++; $display("FAIL reset_dut0 pcb=%b expected 000", {pulse0, clean0, busy0});
    end
    if ({pulse1, clean1, busy1} !== 3'b000) begin
      n_err++; $display("FAIL reset_dut1 pcb=%b expected 000", {pulse1, clean1, busy1});
    end
    @(posedge clk); #3;
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      n_vec += 2;
      if ({pulse0, clean0, busy0} !== {ep0, ec, eb}) begin
        n_err++; $display("FAIL idle_dut0 cyc=%0d pcb=%b expected %b", cyc, {pulse0, clean0, busy0}, {ep0, ec, eb});
      end
      if ({pulse1, clean1, busy1} !== {ep1, ec, eb}) begin
        n_err++; $display("FAIL idle_dut1 cyc=%0d pcb=%b expected %b", cyc, {pulse1, clean1, busy1}, {ep1, ec, eb});
      end
    end
  endtask

  task automatic test_clean_press();
    int e0, r0, np0, tp0, tcr, tcf;
    bit prev_c;
    e0 = 0; r0 = 0; np0 = 0; tp0 = -1; tcr = -1; tcf = -1; prev_c = clean0;
    for (int i = 0; i < 55; i++) begin
      step(i < 40);
      if (i == 0)  e0 = cyc;
      if (i == 40) r0 = cyc;
      n_vec += 2;
      if ({pulse0, clean0, busy0} !== {ep0, ec, eb}) begin
        n_err++; $display("FAIL press_dut0 cyc=%0d pcb=%b expected %b", cyc, {pulse0, clean0, busy0}, {ep0, ec, eb});
      end
      if ({pulse1, clean1, busy1} !== {ep1, ec, eb}) begin
        n_err++; $display("FAIL press_dut1 cyc=%0d pcb=%b expected %b", cyc, {pulse1, clean1, busy1}, {ep1, ec, eb});
      end
      if (pulse0) begin np0++; tp0 = cyc - e0; end
      if (clean0 && !prev_c) tcr = cyc - e0;
      if (!clean0 && prev_c) tcf = cyc - r0;
      prev_c = clean0;
    end
    n_vec += 4;
    if (np0 !== 1)  begin n_err++; $display("FAIL press_count got %0d expected 1", np0); end
    if (tp0 !== 10) begin n_err++; $display("FAIL press_latency got %0d expected 10", tp0); end
    if (tcr !== 10) begin n_err++; $display("FAIL clean_rise got %0d expected 10", tcr); end
    if (tcf !== 10) begin n_err++; $display("FAIL clean_fall got %0d expected 10", tcf); end
  endtask

  task automatic test_glitch();
    int np0, nb0, nc0;
    np0 = 0; nb0 = 0; nc0 = 0;
    for (int i = 0; i < 17; i++) begin
      step(i < 5);
      n_vec += 2;
      if ({pulse0, clean0, busy0} !== {ep0, ec, eb}) begin
        n_err++; $display("FAIL glitch_dut0 cyc=%0d pcb=%b expected %b", cyc, {pulse0, clean0, busy0}, {ep0, ec, eb});
      end
      if ({pulse1, clean1, busy1} !== {ep1, ec, eb}) begin
        n_err++; $display("FAIL glitch_dut1 cyc=%0d pcb=%b expected %b", cyc, {pulse1, clean1, busy1}, {ep1, ec, eb});
      end
      if (pulse0) np0++;
      if (busy0)  nb0++;
      if (clean0) nc0++;
    end
    n_vec += 3;
    if (np0 !== 0) begin n_err++; $display("FAIL glitch_pulses got %0d expected 0", np0); end
    if (nb0 !== 5) begin n_err++; $display("FAIL glitch_busy got %0d expected 5", nb0); end
    if (nc0 !== 0) begin n_err++; $display("FAIL glitch_clean got %0d expected 0", nc0); end
  endtask

  task automatic test_bounce();
    bit pat [5];
    int e0, np0, tp0;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    e0 = 0; np0 = 0; tp0 = -1;
    for (int i = 0; i < 40; i++) begin
      step((i < 5) ? pat[i] : (i < 25));
      if (i == 5) e0 = cyc;
      n_vec += 2;
      if ({pulse0, clean0, busy0} !== {ep0, ec, eb}) begin
        n_err++; $display("FAIL bounce_dut0 cyc=%0d pcb=%b expected %b", cyc, {pulse0, clean0, busy0}, {ep0, ec, eb});
      end
      if ({pulse1, clean1, busy1} !== {ep1, ec, eb}) begin
        n_err++; $display("FAIL bounce_dut1 cyc=%0d pcb=%b expected %b", cyc, {pulse1, clean1, busy1}, {ep1, ec, eb});
      end
      if (pulse0) begin np0++; tp0 = cyc - e0; end
    end
    n_vec += 2;
    if (np0 !== 1)  begin n_err++; $display("FAIL bounce_count got %0d expected 1", np0); end
    if (tp0 !== 10) begin n_err++; $display("FAIL bounce_latency got %0d expected 10", tp0); end
  endtask

  task automatic test_release_bounce();
    int np0, nfall;
    bit prev_c;
    np0 = 0; nfall = 0; prev_c = clean0;
    for (int i = 0; i < 43; i++) begin
      step((i < 15) || (i >= 18 && i < 28));
      n_vec += 2;
      if ({pulse0, clean0, busy0} !== {ep0, ec, eb}) begin
        n_err++; $display("FAIL relbounce_dut0 cyc=%0d pcb=%b expected %b", cyc, {pulse0, clean0, busy0}, {ep0, ec, eb});
      end
      if ({pulse1, clean1, busy1} !== {ep1, ec, eb}) begin
        n_err++; $display("FAIL relbounce_dut1 cyc=%0d pcb=%b expected %b", cyc, {pulse1, clean1, busy1}, {ep1, ec, eb});
      end
      if (pulse0) np0++;
      if (!clean0 && prev_c) nfall++;
      prev_c = clean0;
    end
    n_vec += 2;
    if (np0 !== 1)   begin n_err++; $display("FAIL relbounce_pulses got %0d expected 1", np0); end
    if (nfall !== 1) begin n_err++; $display("FAIL relbounce_clean_falls got %0d expected 1", nfall); end
  endtask

  task automatic test_repeat();
    int exp_t [5];
    int got_t [$];
    int e0;
    exp_t = '{10, 30, 36, 42, 48};
    e0 = 0;
    for (int i = 0; i < 65; i++) begin
      step(i < 50);
      if (i == 0) e0 = cyc;
      n_vec += 2;
      if ({pulse0, clean0, busy0} !== {ep0, ec, eb}) begin
        n_err++; $display("FAIL repeat_dut0 cyc=%0d pcb=%b expected %b", cyc, {pulse0, clean0, busy0}, {ep0, ec, eb});
      end
      if ({pulse1, clean1, busy1} !== {ep1, ec, eb}) begin
        n_err++; $display("FAIL repeat_dut1 cyc=%0d pcb=%b expected %b", cyc, {pulse1, clean1, busy1}, {ep1, ec, eb});
      end
      if (pulse1) got_t.push_back(cyc - e0);
    end
    n_vec++;
    if (got_t.size() !== 5) begin
      n_err++; $display("FAIL repeat_count got %0d expected 5", got_t.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_vec++;
        if (got_t[k] !== exp_t[k]) begin
          n_err++; $display("FAIL repeat_time[%0d] got %0d expected %0d", k, got_t[k], exp_t[k]);
        end
      end
    end
  endtask

  task automatic test_toggle();
    int np0, nc0;
    np0 = 0; nc0 = 0;
    for (int i = 0; i < 52; i++) begin
      step((i < 40) ? ((i % 2) == 0) : 1'b0);
      n_vec += 2;
      if ({pulse0, clean0, busy0} !== {ep0, ec, eb}) begin
        n_err++; $display("FAIL toggle_dut0 cyc=%0d pcb=%b expected %b", cyc, {pulse0, clean0, busy0}, {ep0, ec, eb});
      end
      if ({pulse1, clean1, busy1} !== {ep1, ec, eb}) begin
        n_err++; $display("FAIL toggle_dut1 cyc=%0d pcb=%b expected %b", cyc, {pulse1, clean1, busy1}, {ep1, ec, eb});
      end
      if (pulse0) np0++;
      if (clean0) nc0++;
    end
    n_vec += 2;
    if (np0 !== 0) begin n_err++; $display("FAIL toggle_pulses got %0d expected 0", np0); end
    if (nc0 !== 0) begin n_err++; $display("FAIL toggle_clean got %0d expected 0", nc0); end
  endtask

  task automatic test_reset_mid();
    int e0, np0, tp0;
    e0 = 0; np0 = 0; tp0 = -1;
    for (int i = 0; i < 7; i++) step(1'b1);
    n_vec++;
    if (busy0 !== 1'b1) begin n_err++; $display("FAIL midreset_pre_busy got %b expected 1", busy0); end
    reset = 1'b0;
    #1;
    n_vec += 2;
    if ({pulse0, clean0, busy0} !== 3'b000) begin
      n_err++; $display("FAIL midreset_dut0 pcb=%b expected 000", {pulse0, clean0, busy0});
    end
    if ({pulse1, clean1, busy1} !== 3'b000) begin
      n_err++; $display("FAIL midreset_dut1 pcb=%b expected 000", {pulse1, clean1, busy1});
    end
    @(posedge clk); #3;
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 30; i++) begin
      step(i < 15);
      if (i == 0) e0 = cyc;
      n_vec += 2;
      if ({pulse0, clean0, busy0} !== {ep0, ec, eb}) begin
        n_err++; $display("FAIL midreset_run_dut0 cyc=%0d pcb=%b expected %b", cyc, {pulse0, clean0, busy0}, {ep0, ec, eb});
      end
      if ({pulse1, clean1, busy1} !== {ep1, ec, eb}) begin
        n_err++; $display("FAIL midreset_run_dut1 cyc=%0d pcb=%b expected %b", cyc, {pulse1, clean1, busy1}, {ep1, ec, eb});
      end
      if (pulse0) begin np0++; tp0 = cyc - e0; end
    end
    n_vec += 2;
    if (np0 !== 1)  begin n_err++; $display("FAIL midreset_count got %0d expected 1", np0); end
    if (tp0 !== 10) begin n_err++; $display("FAIL midreset_latency got %0d expected 10", tp0); end
  endtask

  task automatic test_random();
    int unsigned len;
    bit v;
    v = 1'b0;
    for (int seg = 0; seg < 90; seg++) begin
      v = ~v;
      len = $urandom_range(1, 3 * DEB);
      for (int unsigned j = 0; j < len; j++) begin
        step(v);
        n_vec += 2;
        if ({pulse0, clean0, busy0} !== {ep0, ec, eb}) begin
          n_err++; $display("FAIL random_dut0 cyc=%0d pcb=%b expected %b", cyc, {pulse0, clean0, busy0}, {ep0, ec, eb});
        end
        if ({pulse1, clean1, busy1} !== {ep1, ec, eb}) begin
          n_err++; $display("FAIL random_dut1 cyc=%0d pcb=%b expected %b", cyc, {pulse1, clean1, busy1}, {ep1, ec, eb});
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    model_clear();
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_release_bounce();
    test_repeat();
    test_toggle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
